stopwatch_ctrl: RTL

Control sequencer for the stopwatch seconds/minutes counter datapath. It debounces two front-panel buttons (start/stop, lap/reset) and runs the stopwatch state machine. It generates the one-cycle count tick from the system clock, so it replaces the free-running 1 Hz divider. It also drives the clear pulse to the counter and the lap-frozen time feeding the BCD/display path.

---
 rtl/stopwatch_ctrl.sv | 71 +++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced start/stop and lap/reset sequencer driving tick, clear and display of the stopwatch counter
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic [5:0] cnt_min,
  input  logic [5:0] cnt_sec,
  output logic       cnt_tick,
  output logic       cnt_clear,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic       running,
  output logic       lap_active
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
  state_t state, state_n;
  logic [1:0] sync1, sync2, db, flip, press;
  logic [DW-1:0] deb_cnt [2];
  logic [PW-1:0] presc;
  logic [5:0] lap_min, lap_sec;
  logic ss, lr;
  always_comb begin
    for (int i = 0; i < 2; i++) flip[i] = sync2[i] != db[i] && deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1);
    press = flip & ~db;
    ss = press[1];
    lr = press[0] & ~press[1];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ss ? RUN : IDLE;
      RUN:     state_n = ss ? PAUSE : lr ? LAP : RUN;
      LAP:     state_n = ss ? PAUSE : lr ? RUN : LAP;
      default: state_n = ss ? RUN : lr ? IDLE : PAUSE;
    endcase
    running = state == RUN || state == LAP;
    lap_active = state == LAP;
    cnt_tick = running && presc == PW'(TICK_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      state <= IDLE;
      presc <= '0;
      cnt_clear <= 1'b0;
      lap_min <= '0;
      lap_sec <= '0;
      disp_min <= '0;
      disp_sec <= '0;
    end else begin
      sync1 <= {btn_start_stop, btn_lap_reset};
      sync2 <= sync1;
      db <= db ^ flip;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= (sync2[i] == db[i] || flip[i]) ? '0 : deb_cnt[i] + 1'b1;
      state <= state_n;
      presc <= state == IDLE ? '0 : state == PAUSE ? presc : cnt_tick ? '0 : presc + 1'b1;
      cnt_clear <= lr && (state == IDLE || state == PAUSE);
      if (state == RUN && lr) {lap_min, lap_sec} <= {cnt_min, cnt_sec};
      {disp_min, disp_sec} <= (state == LAP && state_n == LAP) ? {lap_min, lap_sec} : {cnt_min, cnt_sec};
    end
  end
endmodule
